// File: rtl/pipe_stage_chain.sv
// ----------------------------------------------------------------------------
// pipe_stage_chain
//   Parametrised chain of DEPTH pipeline registers. It replaces the hand-written
//   per-stage buffers of the 5-stage MIPS core. Stage 0 is the youngest (ID
//   side) and stage DEPTH-1 is the oldest (WB side). Each stage holds a valid
//   bit, an opaque payload, a destination register number and a write-enable.
//   The chain handles stall back-propagation, bubble insertion, partial flush
//   and retirement. It also provides a combinational "youngest matching
//   producer" forwarding lookup for the hazard logic.
//
// Optional feature (compile-time macro PIPE_STAGE_PERF_CNT_EN):
//   When the macro is defined, three 32-bit wrapping performance counters are
//   built. When it is undefined, the perf_* outputs are tied to zero.
//
// Ports:
//   clk          rising-edge clock for all state
//   rst_b        asynchronous reset, active-high
//   in_valid/in_data/in_wr_en/in_rd   new entry offered to stage 0
//   in_ready     stage 0 accepts this cycle
//   stall_req    per-stage hold request; a stall in stage k freezes 0..k
//   flush_req/flush_stage   invalidate stages 0..flush_stage (clamped)
//   stage_valid/stage_data/stage_rd/stage_wr_en   per-stage contents
//   retire_valid oldest stage leaves the chain this cycle
//   src_num      forwarding lookup register numbers, NUM_SRC ports
//   fwd_hit/fwd_sel   per-port hit flag and youngest matching stage index
//   perf_retired/perf_stall/perf_flushed   performance counters
// ----------------------------------------------------------------------------

// One pipeline stage: a flush clears valid only, a hold keeps every field,
// a bubble clears valid, and otherwise the stage loads from its upstream source.
module pipe_stage_cell #(
    parameter int DATA_W = 128,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              flush_i,
    input  logic              hold_i,
    input  logic              bubble_i,
    input  logic              vld_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [REG_W-1:0]  rd_i,
    input  logic              wr_en_i,
    output logic              vld_o,
    output logic [DATA_W-1:0] data_o,
    output logic [REG_W-1:0]  rd_o,
    output logic              wr_en_o
);
    logic              vld_q,   vld_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic [REG_W-1:0]  rd_q,    rd_d;
    logic              wr_en_q, wr_en_d;

    always_comb begin
        vld_d   = vld_q;
        data_d  = data_q;
        rd_d    = rd_q;
        wr_en_d = wr_en_q;
        if (flush_i) begin
            // Flush beats hold. The payload is left stale because valid gates it.
            vld_d = 1'b0;
        end else if (hold_i) begin
            // Frozen: every field keeps its value.
        end else if (bubble_i) begin
            // Upstream is frozen, so nothing enters this stage.
            vld_d = 1'b0;
        end else begin
            vld_d   = vld_i;
            data_d  = data_i;
            rd_d    = rd_i;
            wr_en_d = wr_en_i;
        end
    end

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            vld_q   <= 1'b0;
            data_q  <= '0;
            rd_q    <= '0;
            wr_en_q <= 1'b0;
        end else begin
            vld_q   <= vld_d;
            data_q  <= data_d;
            rd_q    <= rd_d;
            wr_en_q <= wr_en_d;
        end
    end

    assign vld_o   = vld_q;
    assign data_o  = data_q;
    assign rd_o    = rd_q;
    assign wr_en_o = wr_en_q;
endmodule

module pipe_stage_chain #(
    parameter int DEPTH   = 4,
    parameter int DATA_W  = 128,
    parameter int REG_W   = 5,
    parameter int NUM_SRC = 2,
    parameter int SEL_W   = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst_b,
    input  logic                      in_valid,
    input  logic [DATA_W-1:0]         in_data,
    input  logic                      in_wr_en,
    input  logic [REG_W-1:0]          in_rd,
    output logic                      in_ready,
    input  logic [DEPTH-1:0]          stall_req,
    input  logic                      flush_req,
    input  logic [SEL_W-1:0]          flush_stage,
    output logic [DEPTH-1:0]          stage_valid,
    output logic [DEPTH*DATA_W-1:0]   stage_data,
    output logic [DEPTH*REG_W-1:0]    stage_rd,
    output logic [DEPTH-1:0]          stage_wr_en,
    output logic                      retire_valid,
    input  logic [NUM_SRC*REG_W-1:0]  src_num,
    output logic [NUM_SRC-1:0]        fwd_hit,
    output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
    output logic [31:0]               perf_retired,
    output logic [31:0]               perf_stall,
    output logic [31:0]               perf_flushed
);
    logic [DEPTH-1:0]             hold;
    logic [DEPTH-1:0]             flush_vec;
    logic [SEL_W-1:0]             flush_lim;

    logic [DEPTH-1:0]             stg_vld;
    logic [DEPTH-1:0][DATA_W-1:0] stg_data;
    logic [DEPTH-1:0][REG_W-1:0]  stg_rd;
    logic [DEPTH-1:0]             stg_wr_en;

    // Upstream source for each stage: stage 0 takes the input port, and
    // stage i takes stage i-1.
    logic [DEPTH-1:0]             prv_vld;
    logic [DEPTH-1:0][DATA_W-1:0] prv_data;
    logic [DEPTH-1:0][REG_W-1:0]  prv_rd;
    logic [DEPTH-1:0]             prv_wr_en;
    logic [DEPTH-1:0]             bubble;

    // A stall anywhere at or above stage i freezes stage i.
    for (genvar g = 0; g < DEPTH; g++) begin : g_hold
        assign hold[g] = |stall_req[DEPTH-1:g];
    end

    // Out-of-range flush indices (possible when DEPTH is not a power of two)
    // behave like "flush everything".
    always_comb begin
        flush_lim = flush_stage;
        if (int'(flush_stage) > DEPTH - 1) flush_lim = SEL_W'(DEPTH - 1);
        for (int i = 0; i < DEPTH; i++) begin
            flush_vec[i] = flush_req && (i <= int'(flush_lim));
        end
    end

    assign prv_vld   = {stg_vld[DEPTH-2:0],   in_valid};
    assign prv_data  = {stg_data[DEPTH-2:0],  in_data};
    assign prv_rd    = {stg_rd[DEPTH-2:0],    in_rd};
    assign prv_wr_en = {stg_wr_en[DEPTH-2:0], in_wr_en};
    assign bubble    = {hold[DEPTH-2:0],      1'b0};

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        pipe_stage_cell #(
            .DATA_W (DATA_W),
            .REG_W  (REG_W)
        ) u_cell (
            .clk      (clk),
            .rst_b    (rst_b),
            .flush_i  (flush_vec[g]),
            .hold_i   (hold[g]),
            .bubble_i (bubble[g]),
            .vld_i    (prv_vld[g]),
            .data_i   (prv_data[g]),
            .rd_i     (prv_rd[g]),
            .wr_en_i  (prv_wr_en[g]),
            .vld_o    (stg_vld[g]),
            .data_o   (stg_data[g]),
            .rd_o     (stg_rd[g]),
            .wr_en_o  (stg_wr_en[g])
        );
    end

    assign stage_valid  = stg_vld;
    assign stage_data   = stg_data;
    assign stage_rd     = stg_rd;
    assign stage_wr_en  = stg_wr_en;

    // Stage 0 always flushes on any flush, so an offered entry would be lost.
    assign in_ready     = ~hold[0] & ~flush_req;
    assign retire_valid = stg_vld[DEPTH-1] & ~stall_req[DEPTH-1];

    // Forwarding: the scan runs from oldest to youngest so that the last
    // assignment, which is the lowest matching index, wins.
    logic [REG_W-1:0] src_p;
    logic             hit_p;
    logic [SEL_W-1:0] sel_p;

    always_comb begin
        fwd_hit = '0;
        fwd_sel = '0;
        src_p   = '0;
        hit_p   = 1'b0;
        sel_p   = '0;
        for (int p = 0; p < NUM_SRC; p++) begin
            src_p = src_num[p*REG_W +: REG_W];
            hit_p = 1'b0;
            sel_p = '0;
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (stg_vld[i] && stg_wr_en[i] && (stg_rd[i] == src_p) &&
                    (src_p != '0)) begin
                    hit_p = 1'b1;
                    sel_p = SEL_W'(i);
                end
            end
            fwd_hit[p]               = hit_p;
            fwd_sel[p*SEL_W +: SEL_W] = sel_p;
        end
    end

`ifdef PIPE_STAGE_PERF_CNT_EN
    logic [31:0] retired_q, retired_d;
    logic [31:0] stall_q,   stall_d;
    logic [31:0] flushed_q, flushed_d;
    logic [31:0] flush_cnt;

    // Only stages that actually held a valid entry count as flushed.
    always_comb begin
        flush_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (flush_vec[i] && stg_vld[i]) flush_cnt = flush_cnt + 32'd1;
        end
        retired_d = retired_q + {31'd0, retire_valid};
        stall_d   = stall_q + {31'd0, |stall_req};
        flushed_d = flushed_q + flush_cnt;
    end

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            retired_q <= '0;
            stall_q   <= '0;
            flushed_q <= '0;
        end else begin
            retired_q <= retired_d;
            stall_q   <= stall_d;
            flushed_q <= flushed_d;
        end
    end

    assign perf_retired = retired_q;
    assign perf_stall   = stall_q;
    assign perf_flushed = flushed_q;
`else
    assign perf_retired = '0;
    assign perf_stall   = '0;
    assign perf_flushed = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Bench for pipe_stage_chain (DEPTH=4). Inputs are driven 1 time unit after
// the rising edge, and outputs are sampled on the falling edge or shortly
// after the drive. Retired payloads are checked against a scoreboard queue.
module tb_pipe_stage_chain;
    localparam int DEPTH = 4;
    localparam int DW    = 128;

    logic            clk, rst_b;
    logic            in_valid, in_wr_en, in_ready, flush_req, retire_valid;
    logic [DW-1:0]   in_data;
    logic [4:0]      in_rd;
    logic [3:0]      stall_req, stage_valid, stage_wr_en;
    logic [1:0]      flush_stage, fwd_hit;
    logic [DEPTH*DW-1:0] stage_data;
    logic [19:0]     stage_rd;
    logic [9:0]      src_num;
    logic [3:0]      fwd_sel;
    logic [31:0]     perf_retired, perf_stall, perf_flushed;

    int checks = 0;
    int failures = 0;
    bit mon_en = 0;
    logic [7:0] sb[$];

    pipe_stage_chain dut (
        .clk(clk), .rst_b(rst_b), .in_valid(in_valid), .in_data(in_data),
        .in_wr_en(in_wr_en), .in_rd(in_rd), .in_ready(in_ready),
        .stall_req(stall_req), .flush_req(flush_req), .flush_stage(flush_stage),
        .stage_valid(stage_valid), .stage_data(stage_data), .stage_rd(stage_rd),
        .stage_wr_en(stage_wr_en), .retire_valid(retire_valid), .src_num(src_num),
        .fwd_hit(fwd_hit), .fwd_sel(fwd_sel), .perf_retired(perf_retired),
        .perf_stall(perf_stall), .perf_flushed(perf_flushed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog act=timeout req=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h req=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] tag_of(input int s);
        return stage_data[s*DW +: 8];
    endfunction

    task automatic drive(input logic [3:0] st, input logic fl, input logic [1:0] fs,
                         input logic v, input logic [7:0] tag, input logic [4:0] rd,
                         input logic we);
        stall_req = st; flush_req = fl; flush_stage = fs;
        in_valid = v; in_data = DW'(tag); in_rd = rd; in_wr_en = we;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Scoreboard: every retire must match the oldest accepted entry.
    always @(negedge clk) begin
        if (mon_en && !rst_b && retire_valid) begin
            if (sb.size() == 0) chk("sb_underflow", 32'(tag_of(3)), 32'hFFFF);
            else chk("retire_data", 32'(tag_of(3)), 32'(sb.pop_front()));
        end
    end

    typedef struct {
        logic [3:0] stall;
        logic       vin;
        logic [7:0] tag;
        logic       exp_rdy;
        logic       exp_ret;
        logic [3:0] exp_vld;
    } vec_t;
    vec_t tbl[16];

    int found;
    logic [7:0] found_tag;
    logic [31:0] e_ret, e_stl, e_fl;

    initial begin
        tbl[0]  = '{4'b0000, 1'b1, 8'h0A, 1'b1, 1'b0, 4'b0001};
        tbl[1]  = '{4'b0000, 1'b1, 8'h0B, 1'b1, 1'b0, 4'b0011};
        tbl[2]  = '{4'b0000, 1'b1, 8'h0C, 1'b1, 1'b0, 4'b0111};
        tbl[3]  = '{4'b0000, 1'b1, 8'h0D, 1'b1, 1'b0, 4'b1111};
        tbl[4]  = '{4'b0000, 1'b1, 8'h0E, 1'b1, 1'b1, 4'b1111};
        tbl[5]  = '{4'b0100, 1'b1, 8'h0F, 1'b0, 1'b1, 4'b0111};
        tbl[6]  = '{4'b0100, 1'b1, 8'h0F, 1'b0, 1'b0, 4'b0111};
        tbl[7]  = '{4'b0000, 1'b1, 8'h0F, 1'b1, 1'b0, 4'b1111};
        tbl[8]  = '{4'b1000, 1'b1, 8'h10, 1'b0, 1'b0, 4'b1111};
        tbl[9]  = '{4'b0001, 1'b0, 8'h00, 1'b0, 1'b1, 4'b1101};
        tbl[10] = '{4'b0000, 1'b0, 8'h00, 1'b1, 1'b1, 4'b1010};
        tbl[11] = '{4'b0000, 1'b1, 8'h10, 1'b1, 1'b1, 4'b0101};
        tbl[12] = '{4'b0000, 1'b0, 8'h00, 1'b1, 1'b0, 4'b1010};
        tbl[13] = '{4'b0000, 1'b0, 8'h00, 1'b1, 1'b1, 4'b0100};
        tbl[14] = '{4'b0000, 1'b0, 8'h00, 1'b1, 1'b0, 4'b1000};
        tbl[15] = '{4'b0000, 1'b0, 8'h00, 1'b1, 1'b1, 4'b0000};

        rst_b = 1'b1;
        src_num = '0;
        drive(4'b0, 1'b0, 2'd0, 1'b0, 8'h0, 5'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", 32'(stage_valid), 32'h0);
        chk("reset_ready", 32'(in_ready), 32'h1);
        chk("reset_perf", perf_retired | perf_stall | perf_flushed, 32'h0);
        @(negedge clk) rst_b = 1'b0;
        tick();

        // Table-driven stream, stall, and bubble sequence.
        mon_en = 1'b1;
        for (int r = 0; r < 16; r++) begin
            drive(tbl[r].stall, 1'b0, 2'd0, tbl[r].vin, tbl[r].tag, 5'd0, 1'b0);
            @(negedge clk);
            chk($sformatf("ready_r%0d", r), 32'(in_ready), 32'(tbl[r].exp_rdy));
            chk($sformatf("retire_r%0d", r), 32'(retire_valid), 32'(tbl[r].exp_ret));
            if (in_valid && tbl[r].exp_rdy) sb.push_back(tbl[r].tag);
            tick();
            chk($sformatf("valid_r%0d", r), 32'(stage_valid), 32'(tbl[r].exp_vld));
            if (r == 6) chk("stall_hold_data",
                            {8'h0, tag_of(2), tag_of(1), tag_of(0)}, 32'h000C0D0E);
            if (r == 7) chk("stall_release_s3", 32'(tag_of(3)), 32'h0C);
        end
        mon_en = 1'b0;
        chk("sb_drained", sb.size(), 32'd0);

        // Partial flush with a simultaneous offer.
        for (int k = 1; k <= 4; k++) begin
            drive(4'b0, 1'b0, 2'd0, 1'b1, 8'(k), 5'd0, 1'b0);
            tick();
        end
        drive(4'b0000, 1'b1, 2'd1, 1'b1, 8'h05, 5'd0, 1'b0);
        @(negedge clk);
        chk("flush_ready", 32'(in_ready), 32'h0);
        chk("flush_retire", 32'(retire_valid), 32'h1);
        tick();
        chk("flush_valid", 32'(stage_valid), 32'hC);
        chk("flush_s3s2", {16'h0, tag_of(3), tag_of(2)}, 32'h0203);
        // A flush overrides a hold on the oldest stage.
        drive(4'b1000, 1'b1, 2'd3, 1'b0, 8'h0, 5'd0, 1'b0);
        @(negedge clk);
        chk("flush2_retire", 32'(retire_valid), 32'h0);
        tick();
        chk("flush2_valid", 32'(stage_valid), 32'h0);

        // Forwarding lookup.
        drive(4'b0, 1'b0, 2'd0, 1'b1, 8'h11, 5'd5, 1'b1); tick();
        drive(4'b0, 1'b0, 2'd0, 1'b1, 8'h12, 5'd7, 1'b1); tick();
        drive(4'b0, 1'b0, 2'd0, 1'b1, 8'h13, 5'd5, 1'b1); tick();
        drive(4'b0, 1'b0, 2'd0, 1'b1, 8'h14, 5'd9, 1'b0); tick();
        drive(4'b0, 1'b0, 2'd0, 1'b0, 8'h00, 5'd0, 1'b0);
        src_num = {5'd0, 5'd5};
        #1;
        chk("fwd_hit_5_0", 32'(fwd_hit), 32'h1);
        chk("fwd_sel_5_0", 32'(fwd_sel), 32'h1);
        src_num = {5'd9, 5'd7};
        #1;
        chk("fwd_hit_7_9", 32'(fwd_hit), 32'h1);
        chk("fwd_sel_7_9", 32'(fwd_sel), 32'h2);
        drive(4'b1000, 1'b1, 2'd1, 1'b0, 8'h00, 5'd0, 1'b0);
        tick();
        drive(4'b0, 1'b0, 2'd0, 1'b0, 8'h00, 5'd0, 1'b0);
        src_num = {5'd0, 5'd5};
        #1;
        chk("fwd_valid_after", 32'(stage_valid), 32'hC);
        chk("fwd_hit_old", 32'(fwd_hit), 32'h1);
        chk("fwd_sel_old", 32'(fwd_sel), 32'h3);

`ifdef PIPE_STAGE_PERF_CNT_EN
        e_ret = 32'd8; e_stl = 32'd6; e_fl = 32'd6;
`else
        e_ret = 32'd0; e_stl = 32'd0; e_fl = 32'd0;
`endif
        chk("perf_retired", perf_retired, e_ret);
        chk("perf_stall", perf_stall, e_stl);
        chk("perf_flushed", perf_flushed, e_fl);

        // Reset mid-stream, between edges.
        drive(4'b0, 1'b0, 2'd0, 1'b1, 8'h33, 5'd3, 1'b1);
        #2 rst_b = 1'b1;
        #1;
        chk("midrst_valid", 32'(stage_valid), 32'h0);
        chk("midrst_data", 32'(|stage_data), 32'h0);
        chk("midrst_rd_we", {12'h0, stage_rd} | 32'(stage_wr_en), 32'h0);
        chk("midrst_retire", 32'(retire_valid), 32'h0);
        chk("midrst_perf", perf_retired | perf_stall | perf_flushed, 32'h0);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_b = 1'b0;
        drive(4'b0, 1'b0, 2'd0, 1'b1, 8'h77, 5'd0, 1'b0);
        tick();
        in_valid = 1'b0;
        found = -1;
        found_tag = 8'h0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (retire_valid && found < 0) begin
                found = k;
                found_tag = tag_of(3);
            end
        end
        chk("postrst_latency", 32'(found), 32'd3);
        chk("postrst_tag", 32'(found_tag), 32'h77);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
